// File: rtl/hann_window_apply.sv
// Hann window stage: loads coefficients into the external single-port RAM, then multiplies each
// incoming sample by coefficient[n] and streams the rounded product through a small skid FIFO.
module hann_window_apply #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRAME_LEN   = 512,
  parameter int unsigned OFIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  coef_valid,
  output logic                  coef_ready,
  input  logic [DATA_WIDTH-1:0] coef_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  localparam int unsigned CntW = $clog2(OFIFO_DEPTH + 1);
  localparam int unsigned PtrW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int unsigned PW   = 2 * DATA_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [PtrW-1:0]       LastPtr = PtrW'(OFIFO_DEPTH - 1);
  localparam logic signed [PW-1:0]  Half    =
      {{(PW - DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH - 1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] load_idx_q, load_idx_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic                  v1_q, v1_d;
  logic [DATA_WIDTH-1:0] s1_q, s1_d;
  logic                  l1_q, l1_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0]  fifo_data_q [OFIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_data_d [OFIFO_DEPTH];
  logic [OFIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
  logic [PtrW-1:0]        wptr_q, wptr_d;
  logic [PtrW-1:0]        rptr_q, rptr_d;
  logic [CntW-1:0]        count_q, count_d;

  logic                  coef_acc;
  logic                  in_acc;
  logic                  push;
  logic                  pop;
  logic [CntW:0]         occupancy;
  logic signed [PW-1:0]  s1_ext;
  logic signed [PW-1:0]  coef_ext;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  rnd;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  unused_rnd;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign coef_ready = rst_n & ((state_q == StEmpty) | (state_q == StLoad) |
                               ((state_q == StRun) & (n_q == '0) & ~v1_q));
  assign coef_acc    = coef_valid & coef_ready;
  assign ram_wr_en   = coef_acc;
  assign ram_wr_data = coef_data;
  assign ram_addr    = (coef_acc | (state_q == StLoad)) ? load_idx_q : n_q;

  // Slot for the in-flight stage-1 sample is reserved so the push never needs backpressure.
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, v1_q};
  assign in_ready  = (state_q == StRun) & ~coef_acc & (occupancy < (CntW + 1)'(OFIFO_DEPTH));
  assign in_acc    = in_valid & in_ready;

  // Signed sample times unsigned Q0.16 coefficient, round half up, keep bits [31:16].
  assign s1_ext     = PW'($signed(s1_q));
  assign coef_ext   = $signed(PW'(ram_rd_data));
  assign prod       = s1_ext * coef_ext;
  assign rnd        = prod + Half;
  assign win_data   = rnd[2*DATA_WIDTH-1:DATA_WIDTH];
  assign unused_rnd = ^{rnd[PW-1], rnd[DATA_WIDTH-1:0]};

  assign push = v1_q;
  assign pop  = out_valid & out_ready;

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? fifo_data_q[rptr_q] : '0;
  assign out_last  = out_valid & fifo_last_q[rptr_q];
  assign frame_err = err_q;

  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    if (coef_acc) begin
      if (load_idx_q == LastIdx) begin
        load_idx_d = '0;
        state_d    = StRun;
      end else begin
        load_idx_d = load_idx_q + 1'b1;
        state_d    = StLoad;
      end
    end
  end

  always_comb begin
    n_d   = n_q;
    v1_d  = in_acc;
    s1_d  = s1_q;
    l1_d  = l1_q;
    err_d = 1'b0;
    if (in_acc) begin
      s1_d = in_data;
      l1_d = (n_q == LastIdx);
      if (n_q == LastIdx) begin
        n_d   = '0;
        err_d = ~in_last;
      end else begin
        // Early in_last realigns the frame so the next sample uses coefficient 0.
        n_d   = in_last ? '0 : n_q + 1'b1;
        err_d = in_last;
      end
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q + CntW'(push) - CntW'(pop);
    if (push) begin
      fifo_data_d[wptr_q] = win_data;
      fifo_last_d[wptr_q] = l1_q;
      wptr_d              = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      load_idx_q  <= '0;
      n_q         <= '0;
      v1_q        <= 1'b0;
      s1_q        <= '0;
      l1_q        <= 1'b0;
      err_q       <= 1'b0;
      fifo_last_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_idx_q  <= load_idx_d;
      n_q         <= n_d;
      v1_q        <= v1_d;
      s1_q        <= s1_d;
      l1_q        <= l1_d;
      err_q       <= err_d;
      fifo_last_q <= fifo_last_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  // Payload storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_hann_window_apply.sv
// Directed bench for hann_window_apply with FRAME_LEN=8 and a behavioural 1-cycle-latency RAM.
module tb_hann_window_apply;

  localparam int FL = 8;

  logic        clk;
  logic        rst_n;
  logic        coef_valid;
  logic        coef_ready;
  logic [15:0] coef_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        frame_err;
  logic [8:0]  ram_addr;
  logic        ram_wr_en;
  logic [15:0] ram_wr_data;
  logic [15:0] ram_rd_data;

  logic [15:0] ram [512];
  logic [15:0] coef_tab [FL];
  logic [15:0] samp_tab [FL];
  logic [16:0] exp_q [$];
  logic [16:0] got_q [$];

  int checks;
  int errors;
  int err_cnt;

  hann_window_apply #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (16),
    .FRAME_LEN  (FL),
    .OFIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_err  (frame_err),
    .ram_addr   (ram_addr),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_addr];
  end

  // Handshakes are observed mid-cycle; inputs only change 2ns after the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (frame_err) err_cnt++;
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic load_coefs(input int first, input int stop);
    for (int i = first; i < stop; i++) begin
      coef_valid = 1'b1;
      coef_data  = coef_tab[i];
      #1;
      checks++;
      if ({coef_ready, ram_wr_en, in_ready} !== 3'b110 || ram_addr !== 9'(i)) begin
        errors++;
        $display("FAIL load_word%0d: ready/wr_en/in_ready=%b addr=%0d, required 110 addr=%0d",
                 i, {coef_ready, ram_wr_en, in_ready}, ram_addr, i);
      end
      step();
    end
    coef_valid = 1'b0;
  endtask

  task automatic send_samples(input int cnt, input int last_at);
    bit acc;
    int guard;
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_data  = samp_tab[i];
      in_last  = (i == last_at);
      guard    = 0;
      do begin
        #1;
        acc = in_ready;
        step();
        guard++;
      end while (!acc && guard < 50);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: sample %0d not accepted in 50 cycles, required accept", i);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_outputs(input int cnt);
    int guard;
    guard = 0;
    while (got_q.size() < cnt && guard < 100) begin
      step();
      guard++;
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    coef_valid = 1'b0;
    coef_data  = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    repeat (3) step();
    checks++;
    if ({coef_ready, in_ready, out_valid, ram_wr_en, frame_err, out_last} !== 6'b0 ||
        out_data !== 16'h0 || ram_addr !== 9'h0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b data=%h addr=%h, required all zero",
               {coef_ready, in_ready, out_valid, ram_wr_en, frame_err, out_last}, out_data,
               ram_addr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (coef_ready !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: coef_ready=%b in_ready=%b, required 1 0", coef_ready, in_ready);
    end
    step();
  endtask

  task automatic test_window;
    for (int i = 0; i < FL; i++) coef_tab[i] = 16'(i * 'h2000);
    load_coefs(0, FL);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL window_run: in_ready=%b after 8th coef, required 1", in_ready);
    end
    step();
    out_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < FL; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h4000;
      in_last  = (i == FL - 1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL window_in_ready%0d: got %b, required 1", i, in_ready);
      end
      step();
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL window_latency1: out_valid=%b one clk after accept, required 0", out_valid);
        end
      end else if (i == 1) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL window_latency2: out_valid=%b two clks after accept, required 1", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < FL; i++) exp_q.push_back({i == FL - 1, 16'(i * 'h800)});
    wait_outputs(FL);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL window_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL window_out%0d: got last/data=%h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic fill_rounding_tables;
    samp_tab = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h0100, 16'hC000, 16'h4000};
    exp_q.delete();
    exp_q.push_back({1'b0, 16'h7FFF});
    exp_q.push_back({1'b0, 16'h8001});
    exp_q.push_back({1'b0, 16'hFFFF});
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b0, 16'hC000});
    exp_q.push_back({1'b1, 16'h4000});
  endtask

  task automatic test_rounding;
    for (int i = 0; i < FL; i++) coef_tab[i] = 16'hFFFF;
    load_coefs(0, FL);
    fill_rounding_tables();
    got_q.delete();
    out_ready = 1'b1;
    send_samples(FL, FL - 1);
    wait_outputs(FL);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL round_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL round_out%0d: got last/data=%h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int  accepted;
    int  guard;
    bit  acc;
    fill_rounding_tables();
    got_q.delete();
    out_ready = 1'b0;
    accepted  = 0;
    guard     = 0;
    in_valid  = 1'b1;
    while (guard < 10) begin
      in_data = samp_tab[accepted];
      in_last = (accepted == FL - 1);
      #1;
      acc = in_ready;
      step();
      if (acc) accepted++;
      guard++;
    end
    checks++;
    if (accepted != 4) begin
      errors++;
      $display("FAIL stall_accepts: accepted %0d while stalled, required 4", accepted);
    end
    checks++;
    if (out_valid !== 1'b1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL stall_hold: out_valid=%b popped=%0d, required 1 and 0", out_valid, got_q.size());
    end
    out_ready = 1'b1;
    guard     = 0;
    while (accepted < FL && guard < 50) begin
      in_data = samp_tab[accepted];
      in_last = (accepted == FL - 1);
      #1;
      acc = in_ready;
      step();
      if (acc) accepted++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_outputs(FL);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_out%0d: got last/data=%h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_frame_err;
    for (int i = 0; i < FL; i++) coef_tab[i] = 16'(i * 'h2000);
    load_coefs(0, FL);
    for (int i = 0; i < FL; i++) samp_tab[i] = 16'h4000;
    got_q.delete();
    exp_q.delete();
    err_cnt   = 0;
    out_ready = 1'b1;
    send_samples(3, 2);
    step();
    step();
    checks++;
    if (err_cnt != 1) begin
      errors++;
      $display("FAIL early_last_err: frame_err pulses=%0d, required 1", err_cnt);
    end
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b0, 16'h0800});
    exp_q.push_back({1'b0, 16'h1000});
    send_samples(FL, FL - 1);
    for (int i = 0; i < FL; i++) exp_q.push_back({i == FL - 1, 16'(i * 'h800)});
    send_samples(FL, -1);
    for (int i = 0; i < FL; i++) exp_q.push_back({i == FL - 1, 16'(i * 'h800)});
    wait_outputs(exp_q.size());
    step();
    checks++;
    if (err_cnt != 2) begin
      errors++;
      $display("FAIL missing_last_err: frame_err pulses=%0d, required 2", err_cnt);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL align_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL align_out%0d: got last/data=%h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_boundary;
    for (int i = 0; i < FL; i++) coef_tab[i] = 16'hFFFF;
    got_q.delete();
    exp_q.delete();
    out_ready  = 1'b1;
    coef_valid = 1'b1;
    coef_data  = coef_tab[0];
    in_valid   = 1'b1;
    in_data    = 16'h4000;
    #1;
    checks++;
    if ({in_ready, coef_ready, ram_wr_en} !== 3'b011 || ram_addr !== 9'h0) begin
      errors++;
      $display("FAIL boundary_priority: in_ready/coef_ready/wr_en=%b addr=%0d, required 011 0",
               {in_ready, coef_ready, ram_wr_en}, ram_addr);
    end
    step();
    in_valid = 1'b0;
    load_coefs(1, FL);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL boundary_reload: in_ready=%b after reload, required 1", in_ready);
    end
    repeat (3) step();
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL boundary_no_sample: got %0d outputs, required 0", got_q.size());
    end
    for (int i = 0; i < FL; i++) samp_tab[i] = 16'h4000;
    for (int i = 0; i < FL; i++) exp_q.push_back({i == FL - 1, 16'h4000});
    send_samples(FL, FL - 1);
    wait_outputs(FL);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL boundary_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL boundary_out%0d: got last/data=%h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int err_before;
    for (int i = 0; i < FL; i++) samp_tab[i] = 16'h4000;
    out_ready = 1'b0;
    send_samples(3, -1);
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({coef_ready, in_ready, out_valid, ram_wr_en, frame_err, out_last} !== 6'b0 ||
        out_data !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b data=%h, required all zero",
               {coef_ready, in_ready, out_valid, ram_wr_en, frame_err, out_last}, out_data);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (coef_ready !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_empty: coef_ready=%b in_ready=%b, required 1 0", coef_ready, in_ready);
    end
    step();
    got_q.delete();
    exp_q.delete();
    err_before = err_cnt;
    for (int i = 0; i < FL; i++) coef_tab[i] = 16'(i * 'h2000);
    load_coefs(0, 4);
    repeat (3) step();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL partial_load: in_ready=%b after 4 of 8 coefs, required 0", in_ready);
    end
    step();
    load_coefs(4, FL);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_reload: in_ready=%b after 8 coefs, required 1", in_ready);
    end
    step();
    out_ready = 1'b1;
    send_samples(FL, FL - 1);
    for (int i = 0; i < FL; i++) exp_q.push_back({i == FL - 1, 16'(i * 'h800)});
    wait_outputs(FL);
    step();
    checks++;
    if (got_q.size() != exp_q.size() || err_cnt != err_before) begin
      errors++;
      $display("FAIL reload_frame: outputs=%0d errs=%0d, required %0d and %0d",
               got_q.size(), err_cnt - err_before, exp_q.size(), 0);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reload_out%0d: got last/data=%h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    err_cnt = 0;
    test_reset();
    test_window();
    test_rounding();
    test_back_to_back();
    test_frame_err();
    test_boundary();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
